multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mips_pkg.sv | 80 ++++++++
 rtl/multicycle_ctrl_if.sv | 47 ++++
 rtl/instr_decode.sv | 103 ++++++++++
 rtl/multicycle_ctrl.sv | 149 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multicycle MIPS controller
// Purpose : FSM state encoding, opcode/funct constants, control-field
//           encodings and the decoded-field bundle.
// Ports   : none (package).
package mips_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   // Instruction class: selects the FSM path after DECODE
   typedef enum logic [2:0] {
      CLS_NOP,
      CLS_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_JAL,
      CLS_ILLEGAL
   } instr_cls_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0011;
   localparam logic [3:0] ALU_OR   = 4'b0101;
   localparam logic [3:0] ALU_SLT  = 4'b1100;

   localparam logic [1:0] REGDST_RT  = 2'b00;
   localparam logic [1:0] REGDST_RD  = 2'b01;
   localparam logic [1:0] REGDST_R31 = 2'b10;

   localparam logic [1:0] REGSRC_ALU = 2'b00;
   localparam logic [1:0] REGSRC_MEM = 2'b01;
   localparam logic [1:0] REGSRC_PC4 = 2'b10;

   localparam logic [1:0] ALUSRC_REG = 2'b00;
   localparam logic [1:0] ALUSRC_IMM = 2'b01;

   localparam logic [1:0] EXT_SIGN  = 2'b00;
   localparam logic [1:0] EXT_ZERO  = 2'b01;
   localparam logic [1:0] EXT_UPPER = 2'b10;

   typedef struct packed {
      logic [1:0] regdst;
      logic [1:0] regsrc;
      logic [1:0] alusrc;
      logic [1:0] extop;
      logic [3:0] aluop;
   } dec_fields_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller <-> datapath/memory signal bundle
// Purpose : groups instruction, flag, memory handshake and control outputs.
// Modports: master = controller (drives controls), slave = datapath side.
// Config  : MCTRL_ILLEGAL_TRAP_EN adds the 1-bit illegal output.
interface multicycle_ctrl_if;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic        mem_req;
   logic        memwrite;
   logic        irwrite;
   logic        pcwrite;
   logic        regwrite;
   logic [1:0]  regdst;
   logic [1:0]  regsrc;
   logic [1:0]  alusrc;
   logic [1:0]  extop;
   logic [3:0]  aluop;
   logic        npc_sel;
   logic        jump;
   logic [2:0]  state;
`ifdef MCTRL_ILLEGAL_TRAP_EN
   logic        illegal;

   modport master (
      input  instr, zero, mem_ready,
      output mem_req, memwrite, irwrite, pcwrite, regwrite,
             regdst, regsrc, alusrc, extop, aluop, npc_sel, jump, state, illegal
   );
   modport slave (
      output instr, zero, mem_ready,
      input  mem_req, memwrite, irwrite, pcwrite, regwrite,
             regdst, regsrc, alusrc, extop, aluop, npc_sel, jump, state, illegal
   );
`else
   modport master (
      input  instr, zero, mem_ready,
      output mem_req, memwrite, irwrite, pcwrite, regwrite,
             regdst, regsrc, alusrc, extop, aluop, npc_sel, jump, state
   );
   modport slave (
      output instr, zero, mem_ready,
      input  mem_req, memwrite, irwrite, pcwrite, regwrite,
             regdst, regsrc, alusrc, extop, aluop, npc_sel, jump, state
   );
`endif
endinterface

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational instruction-to-control-field decoder
// Purpose : classifies the instruction and produces its datapath fields.
// Ports   : i_instr  - instruction register contents
//           o_cls    - instruction class (CLS_ILLEGAL for unsupported)
//           o_fields - regdst/regsrc/alusrc/extop/aluop for this instruction
module instr_decode
   import mips_pkg::*;
(
   input  logic [31:0] i_instr,
   output instr_cls_t  o_cls,
   output dec_fields_t o_fields
);

   logic [5:0] w_op;
   logic [5:0] w_funct;

   assign w_op    = i_instr[31:26];
   assign w_funct = i_instr[5:0];

   always_comb begin
      o_cls    = CLS_ILLEGAL;
      o_fields = '0;
      // An all-zero word is the canonical NOP regardless of funct decoding
      if (i_instr == 32'd0) begin
         o_cls = CLS_NOP;
      end else begin
         case (w_op)
            OP_RTYPE: begin
               case (w_funct)
                  FN_ADDU: begin
                     o_cls = CLS_ALU;
                     o_fields.regdst = REGDST_RD;
                     o_fields.aluop  = ALU_ADD;
                  end
                  FN_SUBU: begin
                     o_cls = CLS_ALU;
                     o_fields.regdst = REGDST_RD;
                     o_fields.aluop  = ALU_SUB;
                  end
                  FN_SLT: begin
                     o_cls = CLS_ALU;
                     o_fields.regdst = REGDST_RD;
                     o_fields.aluop  = ALU_SLT;
                  end
                  FN_JR:   o_cls = CLS_JUMP;
                  default: o_cls = CLS_ILLEGAL;
               endcase
            end
            OP_J: o_cls = CLS_JUMP;
            OP_JAL: begin
               o_cls = CLS_JAL;
               o_fields.regdst = REGDST_R31;
               o_fields.regsrc = REGSRC_PC4;
            end
            OP_BEQ: begin
               o_cls = CLS_BRANCH;
               o_fields.alusrc = ALUSRC_REG;
               o_fields.aluop  = ALU_SUB;
            end
            OP_ADDI, OP_ADDIU: begin
               o_cls = CLS_ALU;
               o_fields.alusrc = ALUSRC_IMM;
               o_fields.extop  = EXT_SIGN;
               o_fields.aluop  = ALU_ADD;
            end
            OP_SLTI: begin
               o_cls = CLS_ALU;
               o_fields.alusrc = ALUSRC_IMM;
               o_fields.extop  = EXT_SIGN;
               o_fields.aluop  = ALU_SLT;
            end
            OP_ORI: begin
               o_cls = CLS_ALU;
               o_fields.alusrc = ALUSRC_IMM;
               o_fields.extop  = EXT_ZERO;
               o_fields.aluop  = ALU_OR;
            end
            OP_LUI: begin
               // Extender already places imm in the upper half; ALU adds rs ($0)
               o_cls = CLS_ALU;
               o_fields.alusrc = ALUSRC_IMM;
               o_fields.extop  = EXT_UPPER;
               o_fields.aluop  = ALU_ADD;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
               o_cls = CLS_LOAD;
               o_fields.regsrc = REGSRC_MEM;
               o_fields.alusrc = ALUSRC_IMM;
               o_fields.extop  = EXT_SIGN;
               o_fields.aluop  = ALU_ADD;
            end
            OP_SB, OP_SH, OP_SW: begin
               o_cls = CLS_STORE;
               o_fields.alusrc = ALUSRC_IMM;
               o_fields.extop  = EXT_SIGN;
               o_fields.aluop  = ALU_ADD;
            end
            default: o_cls = CLS_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS control FSM
// Purpose : sequences FETCH/DECODE/EXEC/MEM/WB and gates the strobes.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - multicycle_ctrl_if.master (instr, zero, mem_ready in;
//                   memory request, strobes, decoded fields, state out)
// Config  : MCTRL_ILLEGAL_TRAP_EN - unsupported encodings raise illegal
//           and park the FSM in HALT; otherwise they execute as NOP.
module multicycle_ctrl
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   multicycle_ctrl_if.master bus
);

   state_t      r_state;
   logic        r_mem_req;
   logic        r_memwrite;
   logic        r_regwrite;

   instr_cls_t  w_cls;
   dec_fields_t w_dec;
   logic        w_illegal;
   logic        w_in_window;
   logic        w_is_jump;

   instr_decode u_decode (
      .i_instr  (bus.instr),
      .o_cls    (w_cls),
      .o_fields (w_dec)
   );

`ifdef MCTRL_ILLEGAL_TRAP_EN
   assign w_illegal = (w_cls == CLS_ILLEGAL);
`else
   assign w_illegal = 1'b0;
`endif

   // mem_req/memwrite/regwrite are registered on the transition into the
   // state that owns them, so they are already valid for that whole state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_mem_req  <= 1'b0;
         r_memwrite <= 1'b0;
         r_regwrite <= 1'b0;
      end else begin
         r_regwrite <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_state   <= ST_FETCH;
               r_mem_req <= 1'b1;
            end
            ST_FETCH: begin
               if (bus.mem_ready) begin
                  r_state   <= ST_DECODE;
                  r_mem_req <= 1'b0;
               end
            end
            ST_DECODE: begin
               if (w_illegal) begin
                  r_state <= ST_HALT;
               end else begin
                  case (w_cls)
                     CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH: r_state <= ST_EXEC;
                     CLS_JAL: begin
                        r_state    <= ST_WB;
                        r_regwrite <= 1'b1;
                     end
                     default: begin
                        // NOP, j, jr and (untrapped) unsupported encodings
                        r_state   <= ST_FETCH;
                        r_mem_req <= 1'b1;
                     end
                  endcase
               end
            end
            ST_EXEC: begin
               case (w_cls)
                  CLS_LOAD, CLS_STORE: begin
                     r_state    <= ST_MEM;
                     r_mem_req  <= 1'b1;
                     r_memwrite <= (w_cls == CLS_STORE);
                  end
                  CLS_ALU: begin
                     r_state    <= ST_WB;
                     r_regwrite <= 1'b1;
                  end
                  default: begin
                     r_state   <= ST_FETCH;
                     r_mem_req <= 1'b1;
                  end
               endcase
            end
            ST_MEM: begin
               if (bus.mem_ready) begin
                  r_memwrite <= 1'b0;
                  if (w_cls == CLS_LOAD) begin
                     r_state    <= ST_WB;
                     r_mem_req  <= 1'b0;
                     r_regwrite <= 1'b1;
                  end else begin
                     // Store completes straight into the next fetch request
                     r_state   <= ST_FETCH;
                     r_mem_req <= 1'b1;
                  end
               end
            end
            ST_WB: begin
               r_state   <= ST_FETCH;
               r_mem_req <= 1'b1;
            end
            ST_HALT: r_state <= ST_HALT;
            default: begin
               r_state    <= ST_IDLE;
               r_mem_req  <= 1'b0;
               r_memwrite <= 1'b0;
            end
         endcase
      end
   end

   // Decoded fields are visible from DECODE to the instruction's last state
   assign w_in_window = (r_state == ST_DECODE) || (r_state == ST_EXEC) ||
                        (r_state == ST_MEM)    || (r_state == ST_WB);
   assign w_is_jump   = (r_state == ST_DECODE) && !w_illegal &&
                        ((w_cls == CLS_JUMP) || (w_cls == CLS_JAL));

   assign bus.mem_req  = r_mem_req;
   assign bus.memwrite = r_memwrite;
   assign bus.regwrite = r_regwrite;
   assign bus.irwrite  = (r_state == ST_FETCH) && bus.mem_ready;
   assign bus.pcwrite  = ((r_state == ST_FETCH) && bus.mem_ready) || w_is_jump ||
                         ((r_state == ST_EXEC) && (w_cls == CLS_BRANCH) && bus.zero);
   assign bus.jump     = w_is_jump;
   assign bus.npc_sel  = (r_state == ST_EXEC) && (w_cls == CLS_BRANCH);
   assign bus.regdst   = w_in_window ? w_dec.regdst : 2'b00;
   assign bus.regsrc   = w_in_window ? w_dec.regsrc : 2'b00;
   assign bus.alusrc   = w_in_window ? w_dec.alusrc : 2'b00;
   assign bus.extop    = w_in_window ? w_dec.extop  : 2'b00;
   assign bus.aluop    = w_in_window ? w_dec.aluop  : 4'b0000;
   assign bus.state    = r_state;

`ifdef MCTRL_ILLEGAL_TRAP_EN
   assign bus.illegal  = ((r_state == ST_DECODE) && w_illegal) || (r_state == ST_HALT);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

   typedef enum int {K_NOP, K_JUMP, K_JAL, K_BR, K_ALU, K_LD, K_ST, K_BAD} kind_e;

`ifdef MCTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   int          checks;
   int          errors;
   logic [31:0] cur_ins;
   logic        w_ill;
   logic [19:0] w_obs;

   multicycle_ctrl_if bus ();

   multicycle_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

`ifdef MCTRL_ILLEGAL_TRAP_EN
   assign w_ill = bus.illegal;
`else
   assign w_ill = 1'b0;
`endif

   assign w_obs = {w_ill, bus.mem_req, bus.memwrite, bus.irwrite, bus.pcwrite, bus.regwrite,
                   bus.npc_sel, bus.jump, bus.regdst, bus.regsrc, bus.alusrc, bus.extop, bus.aluop};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: observed=still running required=finished");
      $fatal(1, "watchdog expired");
   end

   // Expected output vector, same bit order as w_obs
   function automatic logic [19:0] mk(input logic mreq, input logic mw, input logic irw,
                                      input logic pcw, input logic rw, input logic npc,
                                      input logic jmp, input logic [11:0] f, input logic ill);
      return {ill, mreq, mw, irw, pcw, rw, npc, jmp, f};
   endfunction

   // Reference decode: kind plus {regdst, regsrc, alusrc, extop, aluop}
   function automatic void model_decode(input logic [31:0] ins, output kind_e k, output logic [11:0] f);
      logic [5:0] op;
      logic [5:0] fn;
      op = ins[31:26];
      fn = ins[5:0];
      k  = K_BAD;
      f  = 12'h000;
      if (ins == 32'd0) k = K_NOP;
      else if (op == 6'h00) begin
         case (fn)
            6'h21: begin k = K_ALU; f = 12'b01_00_00_00_0010; end
            6'h23: begin k = K_ALU; f = 12'b01_00_00_00_0011; end
            6'h2A: begin k = K_ALU; f = 12'b01_00_00_00_1100; end
            6'h08: k = K_JUMP;
            default: k = K_BAD;
         endcase
      end else begin
         case (op)
            6'h02: k = K_JUMP;
            6'h03: begin k = K_JAL; f = 12'b10_10_00_00_0000; end
            6'h04: begin k = K_BR;  f = 12'b00_00_00_00_0011; end
            6'h08, 6'h09: begin k = K_ALU; f = 12'b00_00_01_00_0010; end
            6'h0A: begin k = K_ALU; f = 12'b00_00_01_00_1100; end
            6'h0D: begin k = K_ALU; f = 12'b00_00_01_01_0101; end
            6'h0F: begin k = K_ALU; f = 12'b00_00_01_10_0010; end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin k = K_LD; f = 12'b00_01_01_00_0010; end
            6'h28, 6'h29, 6'h2B: begin k = K_ST; f = 12'b00_00_01_00_0010; end
            default: k = K_BAD;
         endcase
      end
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [31:0] ins;
      r = $urandom;
      case ($urandom_range(0, 21))
         0:  ins = {6'h00, r[25:11], 5'd0, 6'h21};
         1:  ins = {6'h00, r[25:11], 5'd0, 6'h23};
         2:  ins = {6'h00, r[25:11], 5'd0, 6'h2A};
         3:  ins = {6'h00, r[25:21], 15'd0, 6'h08};
         4:  ins = {6'h02, r[25:0]};
         5:  ins = {6'h03, r[25:0]};
         6:  ins = {6'h04, r[25:0]};
         7:  ins = {6'h08, r[25:0]};
         8:  ins = {6'h09, r[25:0]};
         9:  ins = {6'h0A, r[25:0]};
         10: ins = {6'h0D, r[25:0]};
         11: ins = {6'h0F, r[25:0]};
         12: ins = {6'h20, r[25:0]};
         13: ins = {6'h21, r[25:0]};
         14: ins = {6'h23, r[25:0]};
         15: ins = {6'h24, r[25:0]};
         16: ins = {6'h25, r[25:0]};
         17: ins = {6'h28, r[25:0]};
         18: ins = {6'h29, r[25:0]};
         19: ins = {6'h2B, r[25:0]};
         20: ins = {6'h3F, r[25:0]};
         default: ins = {6'h00, r[25:6], 6'h20};
      endcase
      return ins;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s instr=%08h observed=%h expected=%h", tag, cur_ins, obs, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, check shortly after
   task automatic step(input logic [31:0] ins, input logic rdy, input logic [2:0] est,
                       input logic [19:0] eo, input string tag);
      @(negedge clk);
      bus.instr     = ins;
      bus.mem_ready = rdy;
      #1;
      chk({tag, "_state"}, {29'd0, bus.state}, {29'd0, est});
      chk({tag, "_outs"}, {12'd0, w_obs}, {12'd0, eo});
   endtask

   // Reset held three cycles, released after a rising edge, then one IDLE cycle
   task automatic do_reset();
      rst_n         = 1'b0;
      bus.mem_ready = 1'b1;
      #1;
      chk("rst_async_state", {29'd0, bus.state}, 32'd0);
      chk("rst_async_outs", {12'd0, w_obs}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("rst_hold_state", {29'd0, bus.state}, 32'd0);
         chk("rst_hold_outs", {12'd0, w_obs}, 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(cur_ins, 1'b0, 3'd0, 20'd0, "idle");
   endtask

   // Runs one instruction starting in FETCH; the DUT ends about to enter FETCH
   task automatic run_instr(input logic [31:0] ins, input logic zv, input int fw, input int mw);
      kind_e       k;
      logic [11:0] f;
      logic        jmp;
      logic        ill;
      model_decode(ins, k, f);
      bus.zero = zv;
      jmp = (k == K_JUMP) || (k == K_JAL);
      ill = TRAP && (k == K_BAD);
      for (int i = 0; i < fw; i++)
         step(cur_ins, 1'b0, 3'd1, mk(1, 0, 0, 0, 0, 0, 0, 12'h0, 0), "fetch_wait");
      step(cur_ins, 1'b1, 3'd1, mk(1, 0, 1, 1, 0, 0, 0, 12'h0, 0), "fetch_done");
      cur_ins = ins;
      step(ins, 1'b0, 3'd2, mk(0, 0, 0, jmp, 0, 0, jmp, f, ill), "decode");
      if (k == K_ALU || k == K_LD || k == K_ST || k == K_BR)
         step(ins, 1'b0, 3'd3, mk(0, 0, 0, (k == K_BR) && zv, 0, k == K_BR, 0, f, 0), "exec");
      if (k == K_LD || k == K_ST) begin
         for (int i = 0; i < mw; i++)
            step(ins, 1'b0, 3'd4, mk(1, k == K_ST, 0, 0, 0, 0, 0, f, 0), "mem_wait");
         step(ins, 1'b1, 3'd4, mk(1, k == K_ST, 0, 0, 0, 0, 0, f, 0), "mem_done");
      end
      if (k == K_ALU || k == K_LD || k == K_JAL)
         step(ins, 1'b0, 3'd5, mk(0, 0, 0, 0, 1, 0, 0, f, 0), "wb");
      if (ill) begin
         for (int i = 0; i < 3; i++)
            step(ins, 1'b1, 3'd6, mk(0, 0, 0, 0, 0, 0, 0, 12'h0, 1), "halt");
         do_reset();
      end
   endtask

   initial begin
      logic [31:0] d_ins [0:16];
      logic        d_z   [0:16];
      int          d_mw  [0:16];
      logic [31:0] sw_ins;
      kind_e       k;
      logic [11:0] f;

      checks        = 0;
      errors        = 0;
      cur_ins       = 32'd0;
      rst_n         = 1'b0;
      bus.instr     = 32'd0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;

      d_ins = '{32'h00221821, 32'h8C220004, 32'h10220003, 32'h10220003, 32'hAC220008,
                32'h08000010, 32'h03E00008, 32'h0C000020, 32'h00000000, 32'h34220FF0,
                32'h3C021234, 32'h28220005, 32'h00221823, 32'h0022182A, 32'h80220000,
                32'hA4220002, 32'hFC000000};
      d_z   = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
      d_mw  = '{0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0};

      do_reset();

      for (int i = 0; i < 17; i++)
         run_instr(d_ins[i], d_z[i], (i == 14) ? 2 : 0, d_mw[i]);

      for (int i = 0; i < 40; i++)
         run_instr(rand_instr(), 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));

      // Store aborted by reset while waiting in MEM
      sw_ins = 32'hAC430010;
      model_decode(sw_ins, k, f);
      step(cur_ins, 1'b1, 3'd1, mk(1, 0, 1, 1, 0, 0, 0, 12'h0, 0), "abort_fetch");
      cur_ins = sw_ins;
      step(sw_ins, 1'b0, 3'd2, mk(0, 0, 0, 0, 0, 0, 0, f, 0), "abort_decode");
      step(sw_ins, 1'b0, 3'd3, mk(0, 0, 0, 0, 0, 0, 0, f, 0), "abort_exec");
      step(sw_ins, 1'b0, 3'd4, mk(1, 1, 0, 0, 0, 0, 0, f, 0), "abort_mem_wait");
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_async_state", {29'd0, bus.state}, 32'd0);
      chk("abort_async_outs", {12'd0, w_obs}, 32'd0);
      bus.mem_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_held_outs", {12'd0, w_obs}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(sw_ins, 1'b0, 3'd0, 20'd0, "abort_idle");
      run_instr(32'h00221821, 1'b0, 1, 0);
      run_instr(32'h8C220004, 1'b0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
